// File: rtl/hd_reconstruct.sv
// rtl/hd_reconstruct.sv - helper-data key reconstruction, 2-stage pipeline + FSM (optional HD_RECON_SOFTFAIL_EN)
// Each row contributes one key bit. The distance d between the captured
// response and the row mask is compared against the stored helper value.
// With HD_RECON_SOFTFAIL_EN defined, an erasure decodes to the nearer centre
// instead of 0.
module hd_reconstruct #(
    parameter int N_ROWS = 128,
    parameter int RESP_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [RESP_W-1:0] Pr,
    input  logic [6:0]        Hsl,
    input  logic [6:0]        Hsh,
    input  logic [6:0]        t,
    input  logic              row_valid,
    output logic              row_ready,
    input  logic [RESP_W-1:0] F_row,
    input  logic [6:0]        hd_in,
    output logic              busy,
    output logic              done,
    output logic [N_ROWS-1:0] Ssk_out,
    output logic [N_ROWS-1:0] erasure_map,
    output logic [7:0]        erasure_cnt
);

    localparam int IDX_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic               row_ready_q;
    logic               busy_q;
    logic               done_q;
    logic [IDX_W-1:0]   idx_q;

    logic [RESP_W-1:0]  pr_q, pr_d;
    logic [6:0]         hsl_q, hsl_d;
    logic [6:0]         hsh_q, hsh_d;
    logic [6:0]         t_q, t_d;

    logic               s1_valid_q, s1_valid_d;
    logic [7:0]         s1_dist_q, s1_dist_d;
    logic [6:0]         s1_hd_q, s1_hd_d;
    logic [IDX_W-1:0]   s1_idx_q, s1_idx_d;

    logic [N_ROWS-1:0]  ssk_q, ssk_d;
    logic [N_ROWS-1:0]  emap_q, emap_d;
    logic [7:0]         ecnt_q, ecnt_d;

    logic               start_accept;
    logic               row_accept;
    logic [RESP_W-1:0]  diff;
    logic [7:0]         pop;
    logic [6:0]         delta;
    logic [6:0]         e1;
    logic [6:0]         e0;
    logic               bit_val;
    logic               is_erasure;

    assign start_accept = (state_q == IDLE) && start;
    assign row_accept   = row_valid && row_ready_q;

    assign row_ready    = row_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign Ssk_out      = ssk_q;
    assign erasure_map  = emap_q;
    assign erasure_cnt  = ecnt_q;

    // Control FSM: sequencing, row index and registered handshake/status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            row_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            idx_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q     <= LOAD;
                        row_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                        idx_q       <= '0;
                    end
                end
                LOAD: begin
                    if (row_accept) begin
                        if (idx_q == LAST_IDX) begin
                            state_q     <= DRAIN;
                            row_ready_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // The last row is still in stage 1 on the first DRAIN cycle
                    if (!s1_valid_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    row_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    // Run configuration is latched only when a start is accepted
    always_comb begin
        pr_d  = pr_q;
        hsl_d = hsl_q;
        hsh_d = hsh_q;
        t_d   = t_q;
        if (start_accept) begin
            pr_d  = Pr;
            hsl_d = Hsl;
            hsh_d = Hsh;
            t_d   = t;
        end
    end

    // Stage 1: Hamming distance between the captured response and the mask row
    always_comb begin
        diff = pr_q ^ F_row;
        pop  = '0;
        for (int k = 0; k < RESP_W; k++) begin
            pop = pop + 8'(diff[k]);
        end
        s1_valid_d = row_accept;
        s1_dist_d  = s1_dist_q;
        s1_hd_d    = s1_hd_q;
        s1_idx_d   = s1_idx_q;
        if (row_accept) begin
            s1_dist_d = pop;
            s1_hd_d   = hd_in;
            s1_idx_d  = idx_q;
        end
    end

    // Stage 2: offset match against both centres and key/erasure bookkeeping
    always_comb begin
        // 8-bit difference truncated to 7 bits gives the mod-128 offset; d=128 acts as 0
        delta      = 7'({1'b0, s1_hd_q} - s1_dist_q);
        e1         = (delta >= hsh_q) ? (delta - hsh_q) : (hsh_q - delta);
        e0         = (delta >= hsl_q) ? (delta - hsl_q) : (hsl_q - delta);
        is_erasure = 1'b0;
        if (e1 <= t_q) begin
            bit_val = 1'b1;
        end else if (e0 <= t_q) begin
            bit_val = 1'b0;
        end else begin
            is_erasure = 1'b1;
`ifdef HD_RECON_SOFTFAIL_EN
            bit_val = (e1 <= e0);
`else
            bit_val = 1'b0;
`endif
        end

        ssk_d  = ssk_q;
        emap_d = emap_q;
        ecnt_d = ecnt_q;
        if (start_accept) begin
            ssk_d  = '0;
            emap_d = '0;
            ecnt_d = '0;
        end else if (s1_valid_q) begin
            ssk_d[s1_idx_q] = bit_val;
            if (is_erasure) begin
                emap_d[s1_idx_q] = 1'b1;
                if (ecnt_q != 8'hFF) begin
                    ecnt_d = ecnt_q + 8'd1;
                end
            end
        end
    end

    // Datapath registers: configuration, pipeline stage 1 and result vectors
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pr_q       <= '0;
            hsl_q      <= '0;
            hsh_q      <= '0;
            t_q        <= '0;
            s1_valid_q <= 1'b0;
            s1_dist_q  <= '0;
            s1_hd_q    <= '0;
            s1_idx_q   <= '0;
            ssk_q      <= '0;
            emap_q     <= '0;
            ecnt_q     <= '0;
        end else begin
            pr_q       <= pr_d;
            hsl_q      <= hsl_d;
            hsh_q      <= hsh_d;
            t_q        <= t_d;
            s1_valid_q <= s1_valid_d;
            s1_dist_q  <= s1_dist_d;
            s1_hd_q    <= s1_hd_d;
            s1_idx_q   <= s1_idx_d;
            ssk_q      <= ssk_d;
            emap_q     <= emap_d;
            ecnt_q     <= ecnt_d;
        end
    end

endmodule
